svca_mux: RTL and testbench
===========================

Name: svca_mux

Overview:
- Time-multiplexed, multi-channel version of the single-channel offset-binary VCA.
- One shared multiplier processes CHANNELS voices in turn, once per sample frame, started by the synth's sample strobe.
- Adds per-channel CV slew smoothing to remove zipper noise on envelope steps, plus a frame-done handshake and an overrun flag.
- Sits between the per-voice oscillator/filter outputs and the voice mixer.

Parameters:
- WIDTH, 8: audio sample width, unsigned offset-binary (midpoint 2^(WIDTH-1) = silence).
- CV_WIDTH, 8: control voltage width, unsigned; gain = cv/2^CV_WIDTH.
- CHANNELS, 4: number of voices processed per frame (>=1).
- SLEW_SHIFT, 3: CV smoothing shift per frame; 0 = smoothing bypassed (cv_s = cv).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- sample_stb  in  1  one-cycle frame start request.
- in_bus  in  CHANNELS*WIDTH  audio inputs, channel k at bits [k*WIDTH +: WIDTH].
- cv_bus  in  CHANNELS*CV_WIDTH  gain CVs, channel k at bits [k*CV_WIDTH +: CV_WIDTH].
- out_bus  out  CHANNELS*WIDTH  registered outputs, same packing as in_bus.
- out_valid  out  1  one-cycle pulse when out_bus has been updated with a full frame.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  one-cycle pulse when sample_stb arrives while busy.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; out_bus = every channel at 2^(WIDTH-1); cv_s = 0 for all channels; out_valid = busy = overrun = 0; pipeline flushed. Reset mid-frame aborts the frame: out_bus is not updated and no out_valid pulse occurs.
- States: IDLE, SMOOTH, RUN, DRAIN, DONE.
- IDLE: on sample_stb at edge E0, latch in_bus and cv_bus into shadow registers; busy<=1; go to SMOOTH. Inputs may change freely after E0.
- SMOOTH (E1): update all cv_s in parallel.
  - d = cv - cv_s, signed CV_WIDTH+1.
  - step = d >>> SLEW_SHIFT (arithmetic). If d != 0 and step == 0, then step = sign(d)*1, which guarantees exact convergence.
  - cv_s <= cv_s + step. Result always stays in 0..2^CV_WIDTH-1.
  - Go to RUN with idx = 0.
- RUN (E2..E(CHANNELS+1)): issue channel idx per cycle into a two-stage pipeline; idx increments; after idx = CHANNELS-1, go to DRAIN.
  - Stage 1 registers p = s_in * s_cv, where s_in = in - 2^(WIDTH-1) (signed WIDTH+1) and s_cv = cv_s zero-extended (signed CV_WIDTH+1); p is signed WIDTH+CV_WIDTH+2.
  - Stage 2 writes buf[k] = ((p >>> CV_WIDTH) + 2^(WIDTH-1)) truncated to WIDTH. Rounding is floor, with no saturation needed: the result is always in range.
- DRAIN: wait for the last stage-2 write (edge E(CHANNELS+2)); go to DONE.
- DONE (edge E(CHANNELS+3)): out_bus <= buf (all channels atomically); out_valid <= 1 for one cycle; busy <= 0; go to IDLE.
- Latency: out_valid is high in the cycle after edge E0+CHANNELS+3 (7 clocks for CHANNELS=4). Minimum strobe period is CHANNELS+3 clocks. A strobe in the same cycle out_valid is high is accepted.
- sample_stb while busy: ignored (the frame in progress is unaffected); overrun pulses for one cycle.
- out_bus holds its value between frames; it is never partially updated.

Test Plan:
- Reset: assert rst 2 cycles mid-frame (CHANNELS=4, WIDTH=8) -> out_bus = 0x80808080, busy=0, no out_valid; cv_s = 0 (next frame with cv=255, SLEW_SHIFT=3 yields cv_s=31).
- Arithmetic, SLEW_SHIFT=0, one strobe:
  - ch0 in=128, cv=200 -> 128
  - ch1 in=255, cv=255 -> 254
  - ch2 in=0, cv=255 -> 0
  - ch3 in=200, cv=64 -> 146
  - out_valid exactly 7 clocks after the strobe edge, one cycle wide.
- Slew, SLEW_SHIFT=3:
  - cv step 0->255 -> cv_s per frame 31, 59, 83, ..., reaches exactly 255 and holds.
  - Step 255->0 -> first frame cv_s=223, reaches exactly 0.
  - Verify the per-frame products match the model using cv_s.
- Channel independence: distinct in/cv per channel, change inputs 1 cycle after strobe -> outputs reflect the latched values only; channel packing correct for all 4 slots.
- Overrun/back-to-back: strobe at E0, again at E0+3, again in the out_valid cycle -> overrun pulse at the second strobe only; first frame unaffected; third strobe starts a new frame, giving out_valid 7 clocks later.
- Parameter sweep: WIDTH=12, CV_WIDTH=10, CHANNELS=1 and 7 -> random stimulus matches the reference model bit-exactly, including in=0/max and cv=0/max (cv=0 -> output 2^(WIDTH-1)).

Source files
------------

// File: rtl/svca_mux.sv
// svca_mux -- time-multiplexed multi-channel offset-binary VCA.
//
// One shared signed multiplier services CHANNELS voices per sample frame.
// A frame is started by sample_stb. The inputs are latched into shadow
// registers, and every channel's CV is slewed once. Each channel then goes
// through a two-stage multiply/rescale pipeline. The finished frame is
// published to out_bus in a single atomic update.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active high
//   sample_stb  one-cycle frame start request
//   in_bus      CHANNELS x WIDTH offset-binary audio, ch k at [k*WIDTH +: WIDTH]
//   cv_bus      CHANNELS x CV_WIDTH gain CVs, ch k at [k*CV_WIDTH +: CV_WIDTH]
//   out_bus     registered outputs, same packing as in_bus
//   out_valid   one-cycle pulse when out_bus holds a new frame
//   busy        high while a frame is in progress
//   overrun     one-cycle pulse when a strobe is dropped because busy

// Per-channel CV slew limiter: cv_s moves toward cv by (cv-cv_s)>>>SLEW_SHIFT
// per update, with a minimum step of 1 LSB so it always lands exactly on cv.
module svca_mux_lane #(
  parameter int CV_WIDTH   = 8,
  parameter int SLEW_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd,
  input  logic [CV_WIDTH-1:0] cv,
  output logic [CV_WIDTH-1:0] cv_s
);
  logic signed [CV_WIDTH:0] d;
  logic signed [CV_WIDTH:0] step;

  always_comb begin
    d    = $signed({1'b0, cv}) - $signed({1'b0, cv_s});
    step = d >>> SLEW_SHIFT;
    // Small differences would shift to zero and stall short of the target.
    if (d != 0 && step == 0)
      step = d[CV_WIDTH] ? '1 : (CV_WIDTH+1)'(1);
  end

  // The result always lies between cv_s and cv, so the modulo-2^CV_WIDTH add is exact.
  always_ff @(posedge clk) begin
    if (rst)      cv_s <= '0;
    else if (upd) cv_s <= cv_s + step[CV_WIDTH-1:0];
  end
endmodule

module svca_mux #(
  parameter int WIDTH      = 8,
  parameter int CV_WIDTH   = 8,
  parameter int CHANNELS   = 4,
  parameter int SLEW_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_stb,
  input  logic [CHANNELS*WIDTH-1:0]    in_bus,
  input  logic [CHANNELS*CV_WIDTH-1:0] cv_bus,
  output logic [CHANNELS*WIDTH-1:0]    out_bus,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);
  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = WIDTH + CV_WIDTH + 2;
  localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0]  LAST = IDXW'(CHANNELS-1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SMOOTH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                         state;
  logic [IDXW-1:0]                    idx;
  logic [CHANNELS-1:0][WIDTH-1:0]     in_sh;
  logic [CHANNELS-1:0][CV_WIDTH-1:0]  cv_sh;
  logic [CHANNELS-1:0][CV_WIDTH-1:0]  cv_s;
  logic [CHANNELS-1:0][WIDTH-1:0]     obuf;

  // Pipeline: stage 1 holds the product, and stage 2 writes obuf.
  logic                               s1_vld;
  logic [IDXW-1:0]                    s1_idx;
  logic signed [PW-1:0]               p;

  logic signed [WIDTH:0]              s_in;
  logic signed [CV_WIDTH:0]           s_cv;
  logic signed [PW-1:0]               prod;

  logic                               accept;

  // CV slewing happens once per frame, for all channels in parallel.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    svca_mux_lane #(.CV_WIDTH(CV_WIDTH), .SLEW_SHIFT(SLEW_SHIFT)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .upd  (state == S_SMOOTH),
      .cv   (cv_sh[k]),
      .cv_s (cv_s[k])
    );
  end

  always_comb begin
    s_in = $signed({1'b0, in_sh[idx]}) - $signed({1'b0, MID});
    s_cv = $signed({1'b0, cv_s[idx]});
    prod = PW'(s_in) * PW'(s_cv);
  end

  // A new frame is accepted when idle, and also in the publish cycle.
  // This allows strobes back to back at the minimum period.
  assign accept = sample_stb && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      in_sh     <= '0;
      cv_sh     <= '0;
      obuf      <= {CHANNELS{MID}};
      s1_vld    <= 1'b0;
      s1_idx    <= '0;
      p         <= '0;
      out_bus   <= {CHANNELS{MID}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_stb && busy && !accept;

      s1_vld <= (state == S_RUN);
      s1_idx <= idx;
      p      <= prod;
      // Floor rescale back to offset binary. The magnitude is bounded, so no saturation is needed.
      if (s1_vld)
        obuf[s1_idx] <= WIDTH'((p >>> CV_WIDTH) + $signed(PW'(MID)));

      if (accept) begin
        in_sh <= in_bus;
        cv_sh <= cv_bus;
        busy  <= 1'b1;
      end

      case (state)
        S_IDLE:   if (accept) state <= S_SMOOTH;
        S_SMOOTH: begin
          idx   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (idx == LAST) state <= S_DRAIN;
          else             idx   <= idx + 1'b1;
        end
        S_DRAIN:  state <= S_DONE;
        S_DONE: begin
          out_bus   <= obuf;
          out_valid <= 1'b1;
          if (accept) state <= S_SMOOTH;
          else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_svca_mux.sv
// tb_svca_mux -- directed checks for svca_mux: reset, arithmetic, slew,
// channel packing, overrun/back-to-back, and a 12/10-bit sweep at 1 and 7 channels.
module tb_svca_mux;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] stb;
  wire  [3:0] ov, bz, orr;
  logic [31:0] in0, cv0, in3, cv3;
  wire  [31:0] ob0, ob3;
  logic [11:0] ina;
  logic [9:0]  cva;
  wire  [11:0] oba;
  logic [83:0] inb;
  logic [69:0] cvb;
  wire  [83:0] obb;

  int nt = 0, nf = 0;

  always #5 clk = ~clk;

  svca_mux #(.WIDTH(8), .CV_WIDTH(8), .CHANNELS(4), .SLEW_SHIFT(0)) u_d0 (
    .clk(clk), .rst(rst), .sample_stb(stb[0]), .in_bus(in0), .cv_bus(cv0),
    .out_bus(ob0), .out_valid(ov[0]), .busy(bz[0]), .overrun(orr[0]));
  svca_mux #(.WIDTH(8), .CV_WIDTH(8), .CHANNELS(4), .SLEW_SHIFT(3)) u_d3 (
    .clk(clk), .rst(rst), .sample_stb(stb[1]), .in_bus(in3), .cv_bus(cv3),
    .out_bus(ob3), .out_valid(ov[1]), .busy(bz[1]), .overrun(orr[1]));
  svca_mux #(.WIDTH(12), .CV_WIDTH(10), .CHANNELS(1), .SLEW_SHIFT(0)) u_da (
    .clk(clk), .rst(rst), .sample_stb(stb[2]), .in_bus(ina), .cv_bus(cva),
    .out_bus(oba), .out_valid(ov[2]), .busy(bz[2]), .overrun(orr[2]));
  svca_mux #(.WIDTH(12), .CV_WIDTH(10), .CHANNELS(7), .SLEW_SHIFT(0)) u_db (
    .clk(clk), .rst(rst), .sample_stb(stb[3]), .in_bus(inb), .cv_bus(cvb),
    .out_bus(obb), .out_valid(ov[3]), .busy(bz[3]), .overrun(orr[3]));

  task automatic chk(input string tag, input longint got, input longint exp);
    nt++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int vca(int x, int c, int w, int cw);
    int s;
    s = (x - (1 << (w-1))) * c;
    return ((s >>> cw) + (1 << (w-1))) & ((1 << w) - 1);
  endfunction

  function automatic int slew(int cs, int c, int ss);
    int d, st;
    d  = c - cs;
    st = d >>> ss;
    if (d != 0 && st == 0) st = (d > 0) ? 1 : -1;
    return cs + st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the strobe edge until out_valid is seen (99 = timeout).
  task automatic wait_valid(input int sel, output int lat);
    lat = 99;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ov[sel]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic frame(input int sel, output int lat);
    stb[sel] = 1'b1;
    tick();
    stb[sel] = 1'b0;
    wait_valid(sel, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cs, cnt, o3;
    int ins3 [4];
    int xa, ca;
    int xb [7];
    int cb [7];
    rst = 1'b1; stb = '0;
    in0 = '0; cv0 = '0; in3 = '0; cv3 = '0; ina = '0; cva = '0; inb = '0; cvb = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_out0", ob0, 32'h80808080);
    chk("rst_outa", oba, 12'h800);
    chk("rst_busy", bz, 4'h0);
    chk("rst_valid", ov, 4'h0);
    chk("rst_ovr", orr, 4'h0);

    // Reset mid-frame on the slewed instance, after its CV was already smoothed.
    ins3 = '{255, 0, 200, 60};
    in3 = {8'd60, 8'd200, 8'd0, 8'd255};
    cv3 = 32'hFFFFFFFF;
    stb[1] = 1'b1; tick(); stb[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (ov[1]) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    chk("midrst_out", ob3, 32'h80808080);
    chk("midrst_busy", bz[1], 1'b0);

    // The first frame after reset starts slewing from cv_s=0, which gives 31.
    cs = slew(0, 255, 3);
    frame(1, lat);
    chk("slew_lat", lat, 7);
    chk("slew_first_ch0", ob3[7:0], 143);
    for (int k = 1; k < 4; k++) chk("slew_first_ch", ob3[k*8 +: 8], vca(ins3[k], cs, 8, 8));
    for (int f = 0; f < 45; f++) begin
      cs = slew(cs, 255, 3);
      frame(1, lat);
      for (int k = 0; k < 4; k++) chk("slew_up", ob3[k*8 +: 8], vca(ins3[k], cs, 8, 8));
    end
    chk("slew_up_conv", ob3[7:0], 254);
    cv3 = 32'h0;
    cs = slew(cs, 0, 3);
    frame(1, lat);
    chk("slew_down_first", ob3[7:0], 238);
    for (int f = 0; f < 45; f++) begin
      cs = slew(cs, 0, 3);
      frame(1, lat);
      for (int k = 0; k < 4; k++) chk("slew_down", ob3[k*8 +: 8], vca(ins3[k], cs, 8, 8));
    end
    chk("slew_down_conv", ob3, 32'h80808080);

    // Arithmetic with smoothing bypassed.
    in0 = {8'd200, 8'd0, 8'd255, 8'd128};
    cv0 = {8'd64, 8'd255, 8'd255, 8'd200};
    stb[0] = 1'b1; tick(); stb[0] = 1'b0;
    chk("arith_busy", bz[0], 1'b1);
    wait_valid(0, lat);
    chk("arith_lat", lat, 7);
    chk("arith_out", ob0, 32'h9200FE80);
    tick();
    chk("arith_valid_width", ov[0], 1'b0);
    chk("arith_idle", bz[0], 1'b0);
    chk("arith_hold", ob0, 32'h9200FE80);

    // Inputs change right after the strobe, so only the latched values may appear.
    in0 = {8'd10, 8'd90, 8'd170, 8'd250};
    cv0 = {8'd33, 8'd99, 8'd150, 8'd222};
    stb[0] = 1'b1; tick(); stb[0] = 1'b0;
    in0 = 32'h5A5A5A5A; cv0 = 32'hC3C3C3C3;
    wait_valid(0, lat);
    chk("indep_out", ob0, 32'h707198E9);

    // Overrun: strobes at E0, at E0+3 (dropped), and in the out_valid cycle (accepted).
    in0 = {8'd10, 8'd90, 8'd170, 8'd250};
    cv0 = {8'd33, 8'd99, 8'd150, 8'd222};
    tick();
    stb[0] = 1'b1; tick();
    cnt = 0; o3 = 0; lat = 99;
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) begin
        stb[0] = 1'b1; in0 = 32'h01020304; cv0 = 32'hFFFFFFFF;
      end else stb[0] = 1'b0;
      tick();
      if (orr[0]) cnt++;
      if (c == 3) o3 = orr[0];
      if (ov[0] && lat == 99) lat = c;
    end
    stb[0] = 1'b0;
    chk("ovr_at_second", o3, 1);
    chk("ovr_count", cnt, 1);
    chk("ovr_first_lat", lat, 7);
    chk("ovr_first_out", ob0, 32'h707198E9);
    in0 = 32'hFF00FF00; cv0 = 32'hFFFFFFFF;
    stb[0] = 1'b1; tick(); stb[0] = 1'b0;
    chk("ovr_third_none", orr[0], 1'b0);
    wait_valid(0, lat);
    chk("ovr_third_lat", lat, 7);
    chk("ovr_third_out", ob0, 32'hFE00FE00);

    // 12/10-bit sweep, one channel.
    for (int f = 0; f < 12; f++) begin
      xa = (f == 0) ? 0 : (f == 1) ? 4095 : $urandom_range(4095);
      ca = (f == 2) ? 0 : (f < 2) ? 1023 : $urandom_range(1023);
      ina = 12'(xa); cva = 10'(ca);
      frame(2, lat);
      if (f == 0) chk("sweep1_lat", lat, 4);
      chk("sweep1_out", oba, vca(xa, ca, 12, 10));
    end
    chk("sweep1_cv0", oba == 12'h800 || ca != 0, 1'b1);

    // 12/10-bit sweep, seven channels, with edge values mixed in.
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 7; k++) begin
        case ($urandom_range(3))
          0:       xb[k] = 0;
          1:       xb[k] = 4095;
          default: xb[k] = $urandom_range(4095);
        endcase
        case ($urandom_range(3))
          0:       cb[k] = 0;
          1:       cb[k] = 1023;
          default: cb[k] = $urandom_range(1023);
        endcase
        if (f == 0) cb[k] = 0;
        inb[k*12 +: 12] = 12'(xb[k]);
        cvb[k*10 +: 10] = 10'(cb[k]);
      end
      frame(3, lat);
      if (f == 0) begin
        chk("sweep7_lat", lat, 10);
        for (int k = 0; k < 7; k++) chk("sweep7_cv0", obb[k*12 +: 12], 12'h800);
      end
      for (int k = 0; k < 7; k++) chk("sweep7_out", obb[k*12 +: 12], vca(xb[k], cb[k], 12, 10));
    end

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
